// File: rtl/pwm_pkg.sv
// Constants shared by the PWM generator, the PWM capture block and the TT06 top level.
package pwm_pkg;

  localparam int DUTY_W   = 7;
  localparam int PCT_FULL = 100;
  localparam int DIV_LAT  = 9;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

endpackage

// File: rtl/pwm_div_seq.sv
// Restoring divider producing a DUTY_W-bit quotient, one bit per cycle after a load cycle.
// The caller guarantees num < 2^DUTY_W * den, so the quotient always fits.
module pwm_div_seq
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W+DUTY_W-1:0]  num,
  input  logic [CNT_W-1:0]         den,
  output logic                     busy,
  output logic                     done,
  output logic [DUTY_W-1:0]        quo
);

  localparam int NUM_W = CNT_W + DUTY_W;

  div_state_e        state_q, state_d;
  logic [NUM_W-1:0]  rem_q, rem_d;
  logic [NUM_W-1:0]  dsh_q, dsh_d;
  logic [DUTY_W-1:0] q_q, q_d;
  logic [2:0]        step_q, step_d;
  logic              ge;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dsh_d   = dsh_q;
    q_d     = q_q;
    step_d  = step_q;
    ge      = (rem_q >= dsh_q);

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_RUN;
          rem_d   = num;
          dsh_d   = NUM_W'(den) << (DUTY_W - 1);
          q_d     = '0;
          step_d  = '0;
        end
      end
      DIV_RUN: begin
        if (ge) rem_d = rem_q - dsh_q;
        dsh_d  = dsh_q >> 1;
        q_d    = {q_q[DUTY_W-2:0], ge};
        step_d = step_q + 3'd1;
        if (step_q == 3'(DUTY_W - 1)) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // The final quotient bit is taken combinationally so the result is usable in the last step cycle.
  assign busy = (state_q == DIV_RUN);
  assign done = busy && (step_q == 3'(DUTY_W - 1));
  assign quo  = {q_q[DUTY_W-2:0], ge};

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      dsh_q   <= '0;
      q_q     <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dsh_q   <= dsh_d;
      q_q     <= q_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input and reports a rounded duty percentage.
// Also flags a stuck input when no rising edge arrives within TIMEOUT cycles.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  period_out,
  output logic              valid,
  output logic              busy,
  output logic              stuck
);

  localparam int               NUM_W   = CNT_W + DUTY_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              sync1_q, s_q, s_dly_q;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic              armed_q, armed_d;
  logic              start_q, start_d;
  logic [CNT_W-1:0]  p_q, p_d;
  logic [CNT_W-1:0]  h_q, h_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_q, valid_d;
  logic              stuck_q, stuck_d;

  logic              rise, period_sat, busy_w, capture, timeout_hit;
  logic              div_busy, div_done;
  logic [DUTY_W-1:0] div_quo;
  logic [NUM_W-1:0]  div_num;

  // Adding P/2 before dividing rounds the percentage to nearest.
  assign div_num = NUM_W'(h_q) * NUM_W'(PCT_FULL) + NUM_W'(p_q >> 1);

  pwm_div_seq #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (start_q),
    .num   (div_num),
    .den   (p_q),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_comb begin
    rise        = s_q & ~s_dly_q;
    period_sat  = (period_cnt_q == CNT_MAX);
    busy_w      = start_q | div_busy;
    capture     = rise && armed_q && !busy_w && !period_sat;
    // A rise in the same cycle suppresses the timeout; stuck_q keeps it to one report.
    timeout_hit = !rise && (period_cnt_q == CNT_W'(TIMEOUT)) && !stuck_q;

    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    if (rise) begin
      period_cnt_d = CNT_W'(1);
      high_cnt_d   = CNT_W'(1);
    end else begin
      if (!period_sat)                  period_cnt_d = period_cnt_q + CNT_W'(1);
      if (s_q && high_cnt_q != CNT_MAX) high_cnt_d   = high_cnt_q + CNT_W'(1);
    end

    armed_d = armed_q;
    if (rise)             armed_d = 1'b1;
    else if (timeout_hit) armed_d = 1'b0;

    start_d = capture;
    p_d     = capture ? period_cnt_q : p_q;
    h_d     = capture ? high_cnt_q   : h_q;

    duty_d   = duty_q;
    period_d = period_q;
    stuck_d  = stuck_q;
    valid_d  = 1'b0;
    if (div_done) begin
      duty_d   = div_quo;
      period_d = p_q;
      stuck_d  = 1'b0;
      valid_d  = 1'b1;
    end else if (timeout_hit) begin
      duty_d   = s_q ? DUTY_W'(PCT_FULL) : '0;
      period_d = '0;
      stuck_d  = 1'b1;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      s_dly_q      <= 1'b0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      armed_q      <= 1'b0;
      start_q      <= 1'b0;
      p_q          <= '0;
      h_q          <= '0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      sync1_q      <= pwm_in;
      s_q          <= sync1_q;
      s_dly_q      <= s_q;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      armed_q      <= armed_d;
      start_q      <= start_d;
      p_q          <= p_d;
      h_q          <= h_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
    end
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign busy       = busy_w;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus randomized waveforms checked
// against an event-level model built from the sampled input history.
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int TMO   = 20;
  localparam int MAXC  = 4096;

  typedef struct packed {
    int cyc;
    int duty;
    int period;
    bit stk;
  } ev_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pwm_in = 1'b0;
  logic [6:0]       duty_out;
  logic [CNT_W-1:0] period_out;
  logic             valid, busy, stuck;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  bit  drv [MAXC];
  bit  bsy [MAXC];
  ev_t obs[$];
  ev_t exp_q[$];

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .valid      (valid),
    .busy       (busy),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  // Edge e samples pwm_in into drv[e]; cycle c is the interval after edge c.
  always @(posedge clk) begin
    if (!reset && cyc < MAXC - 1) begin
      cyc = cyc + 1;
      drv[cyc] = pwm_in;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      bsy[cyc] = busy;
      if (valid) obs.push_back('{cyc, int'(duty_out), int'(period_out), stuck});
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the synchronised level in cycle c is drv[c-1]. Rises measure the interval since
  // the previous rise; captures need an armed block and a divider free for 9 cycles.
  function automatic void model_events(input int n);
    int last = 0, capt = -100, p, h;
    bit armed = 0, stk = 0, s, sd;
    exp_q.delete();
    for (int c = 1; c <= n; c++) begin
      s  = drv[c-1];
      sd = (c >= 2) ? drv[c-2] : 1'b0;
      if (s && !sd) begin
        if (armed && (c - capt) >= 9) begin
          p = c - last;
          h = 0;
          for (int k = last; k < c; k++) h += (k >= 1) ? int'(drv[k-1]) : 0;
          if (c + 9 <= n) exp_q.push_back('{c + 9, (100 * h + p / 2) / p, p, 1'b0});
          capt = c;
          stk  = 0;
        end
        armed = 1;
        last  = c;
      end else if ((c - last) == TMO && !stk) begin
        if (c + 1 <= n) exp_q.push_back('{c + 1, s ? 100 : 0, 0, 1'b1});
        stk   = 1;
        armed = 0;
      end
    end
  endfunction

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = v;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    cyc = 0;
    obs.delete();
    drv = '{default: 1'b0};
    bsy = '{default: 1'b0};
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({duty_out, period_out, valid, busy, stuck} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: outputs=%h expected all zero", {duty_out, period_out, valid, busy, stuck});
    end
    apply_reset();
    drive(1'b0, 3);
    #1;
    n_cmp++;
    if ({duty_out, period_out, valid, busy, stuck} !== '0 || obs.size() != 0) begin
      n_err++;
      $display("FAIL reset_release: outputs=%h valids=%0d expected zero/0",
               {duty_out, period_out, valid, busy, stuck}, obs.size());
    end
  endtask

  task automatic test_duty();
    int e0;
    apply_reset();
    drive(1'b1, 3); drive(1'b0, 7);
    e0 = cyc;
    for (int i = 0; i < 3; i++) begin drive(1'b1, 3); drive(1'b0, 7); end
    #1;
    n_cmp++;
    if (obs.size() < 1 || obs[0].cyc != e0 + 11 || obs[0].duty != 30 || obs[0].period != 10) begin
      n_err++;
      $display("FAIL duty30_first: got n=%0d cyc=%0d duty=%0d per=%0d, expected cyc=%0d duty=30 per=10",
               obs.size(), (obs.size() > 0) ? obs[0].cyc : -1, (obs.size() > 0) ? obs[0].duty : -1,
               (obs.size() > 0) ? obs[0].period : -1, e0 + 11);
    end
    n_cmp++;
    if ({bsy[e0+2], bsy[e0+3], bsy[e0+10], bsy[e0+11]} !== 4'b0110) begin
      n_err++;
      $display("FAIL busy_window: busy at T,T+1,T+8,T+9 = %b expected 0110",
               {bsy[e0+2], bsy[e0+3], bsy[e0+10], bsy[e0+11]});
    end
    model_events(cyc);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL duty30_count: got %0d valids, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL duty30_ev%0d: got cyc=%0d duty=%0d per=%0d stuck=%0d, expected cyc=%0d duty=%0d per=%0d stuck=%0d",
                 i, obs[i].cyc, obs[i].duty, obs[i].period, obs[i].stk,
                 exp_q[i].cyc, exp_q[i].duty, exp_q[i].period, exp_q[i].stk);
      end
    end
  endtask

  task automatic test_rounding();
    apply_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1); drive(1'b0, 2); end
    drive(1'b0, 12);
    #1;
    n_cmp++;
    if (obs.size() < 1 || obs[0].duty != 33 || obs[0].period != 3) begin
      n_err++;
      $display("FAIL round_33: got n=%0d duty=%0d per=%0d, expected duty=33 per=3",
               obs.size(), (obs.size() > 0) ? obs[0].duty : -1, (obs.size() > 0) ? obs[0].period : -1);
    end
    apply_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 2); drive(1'b0, 1); end
    drive(1'b0, 12);
    #1;
    n_cmp++;
    if (obs.size() < 1 || obs[0].duty != 67 || obs[0].period != 3) begin
      n_err++;
      $display("FAIL round_67: got n=%0d duty=%0d per=%0d, expected duty=67 per=3",
               obs.size(), (obs.size() > 0) ? obs[0].duty : -1, (obs.size() > 0) ? obs[0].period : -1);
    end
  endtask

  task automatic test_timeout_high();
    apply_reset();
    drive(1'b1, 25);
    #1;
    n_cmp++;
    if (obs.size() != 1 || obs[0].duty != 100 || obs[0].period != 0 || stuck !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_high: got n=%0d duty=%0d per=%0d stuck=%b, expected n=1 duty=100 per=0 stuck=1",
               obs.size(), (obs.size() > 0) ? obs[0].duty : -1, (obs.size() > 0) ? obs[0].period : -1, stuck);
    end
    for (int i = 0; i < 3; i++) begin drive(1'b0, 5); drive(1'b1, 5); end
    drive(1'b0, 12);
    #1;
    n_cmp++;
    if (obs.size() < 2 || obs[1].duty != 50 || obs[1].period != 10 || obs[1].stk != 1'b0 || stuck !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_recover: got n=%0d duty=%0d per=%0d stuck=%b, expected duty=50 per=10 stuck=0",
               obs.size(), (obs.size() > 1) ? obs[1].duty : -1, (obs.size() > 1) ? obs[1].period : -1, stuck);
    end
    model_events(cyc);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL tmo_high_count: got %0d valids, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL tmo_high_ev%0d: got cyc=%0d duty=%0d per=%0d stuck=%0d, expected cyc=%0d duty=%0d per=%0d stuck=%0d",
                 i, obs[i].cyc, obs[i].duty, obs[i].period, obs[i].stk,
                 exp_q[i].cyc, exp_q[i].duty, exp_q[i].period, exp_q[i].stk);
      end
    end
  endtask

  task automatic test_timeout_low();
    apply_reset();
    drive(1'b0, 30);
    #1;
    n_cmp++;
    if (obs.size() != 1 || obs[0].cyc != TMO + 1 || obs[0].duty != 0 || obs[0].period != 0 || stuck !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_low: got n=%0d cyc=%0d duty=%0d stuck=%b, expected n=1 cyc=%0d duty=0 stuck=1",
               obs.size(), (obs.size() > 0) ? obs[0].cyc : -1, (obs.size() > 0) ? obs[0].duty : -1, stuck, TMO + 1);
    end
    drive(1'b0, 40);
    #1;
    n_cmp++;
    if (obs.size() != 1) begin
      n_err++;
      $display("FAIL tmo_low_once: got %0d valids, expected 1", obs.size());
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 12; i++) begin drive(1'b1, 2); drive(1'b0, 2); end
    drive(1'b0, 12);
    #1;
    n_cmp++;
    if (obs.size() < 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d valids, expected at least 2", obs.size());
    end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i].duty != 50 || obs[i].period != 4 || (i > 0 && obs[i].cyc - obs[i-1].cyc < 9)) begin
        n_err++;
        $display("FAIL b2b_ev%0d: got cyc=%0d duty=%0d per=%0d, expected duty=50 per=4 spacing>=9",
                 i, obs[i].cyc, obs[i].duty, obs[i].period);
      end
    end
    model_events(cyc);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL b2b_model_count: got %0d valids, expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i].cyc != exp_q[i].cyc) begin
        n_err++;
        $display("FAIL b2b_latency%0d: got cyc=%0d, expected cyc=%0d", i, obs[i].cyc, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int e0;
    apply_reset();
    drive(1'b1, 3); drive(1'b0, 7); drive(1'b1, 3); drive(1'b0, 7);
    e0 = cyc;
    drive(1'b1, 3);
    pwm_in = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || bsy[e0+3] !== 1'b1 || duty_out !== 7'd30) begin
      n_err++;
      $display("FAIL middiv_setup: busy=%b duty=%0d, expected busy=1 duty=30", busy, duty_out);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({duty_out, period_out, valid, busy, stuck} !== '0) begin
      n_err++;
      $display("FAIL middiv_reset: outputs=%h expected all zero", {duty_out, period_out, valid, busy, stuck});
    end
    apply_reset();
    drive(1'b0, 12);
    #1;
    n_cmp++;
    if (obs.size() != 0) begin
      n_err++;
      $display("FAIL middiv_novalid: got %0d valids, expected 0", obs.size());
    end
    for (int i = 0; i < 3; i++) begin drive(1'b1, 3); drive(1'b0, 7); end
    #1;
    n_cmp++;
    if (obs.size() < 1 || obs[0].duty != 30 || obs[0].period != 10) begin
      n_err++;
      $display("FAIL middiv_recover: got n=%0d duty=%0d per=%0d, expected duty=30 per=10",
               obs.size(), (obs.size() > 0) ? obs[0].duty : -1, (obs.size() > 0) ? obs[0].period : -1);
    end
  endtask

  task automatic test_random(input int max_len, input string tag);
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7, 0) == 0) drive($urandom_range(1, 0) == 1, 22 + $urandom_range(5, 0));
      drive(1'b1, $urandom_range(max_len, 1));
      drive(1'b0, $urandom_range(max_len, 1));
    end
    drive(1'b0, 12);
    #1;
    model_events(cyc);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s_count: got %0d valids, expected %0d", tag, obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s_ev%0d: got cyc=%0d duty=%0d per=%0d stuck=%0d, expected cyc=%0d duty=%0d per=%0d stuck=%0d",
                 tag, i, obs[i].cyc, obs[i].duty, obs[i].period, obs[i].stk,
                 exp_q[i].cyc, exp_q[i].duty, exp_q[i].period, exp_q[i].stk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_rounding();
    test_timeout_high();
    test_timeout_low();
    test_back_to_back();
    test_reset_mid_div();
    test_random(12, "rand_long");
    test_random(3, "rand_short");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
